// File: rtl/tstream_serializer_if.sv
// rtl/tstream_serializer_if.sv - ACT/NEXT wide-in / narrow-out bundle for the downsizing serializer.
// slave is the serializer's view; master is the producer/consumer side.
interface tstream_serializer_if #(
   parameter int Width = 8,
   parameter int Ratio = 4
);
   logic                        ACTL;
   logic                        NEXTL;
   logic [Width*Ratio-1:0]      DI;
   logic [$clog2(Ratio)-1:0]    SZ;
   logic                        ACTH;
   logic                        NEXTH;
   logic [Width-1:0]            DO;
   logic                        LAST;

   modport slave (
      input  ACTL, DI, SZ, NEXTH,
      output NEXTL, ACTH, DO, LAST
   );

   modport master (
      output ACTL, DI, SZ, NEXTH,
      input  NEXTL, ACTH, DO, LAST
   );
endinterface

// File: rtl/tstream_serializer.sv
// rtl/tstream_serializer.sv - downsizing ACT/NEXT serializer, wide word in, LSB-first narrow beats out.
// A holding register refills while the shift register drains, so multi-beat words run back to back.
module tstream_serializer #(
   parameter int Width = 8,
   parameter int Ratio = 4
) (
   input logic CLK,
   input logic RESET,
   tstream_serializer_if.slave bus
);
   localparam int CW = $clog2(Ratio);
   localparam int WW = Width * Ratio;
   localparam int SW = Width * (Ratio - 1);

   logic [WW-1:0]    hr_q, hr_d;
   logic [CW-1:0]    hsz_q, hsz_d;
   logic             hv_q, hv_d;
   logic [SW-1:0]    sr_q, sr_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic [Width-1:0] do_q, do_d;
   logic             last_q, last_d;
   logic             acth_q, acth_d;
   logic             out_free;
   logic             accept;

   assign out_free = ~acth_q | bus.NEXTH;
   assign accept   = bus.ACTL & ~hv_q;

   always_comb begin
      hr_d   = hr_q;
      hsz_d  = hsz_q;
      hv_d   = hv_q;
      sr_d   = sr_q;
      rem_d  = rem_q;
      do_d   = do_q;
      last_d = last_q;
      acth_d = acth_q;

      if (accept) begin
         hr_d  = bus.DI;
         hsz_d = bus.SZ;
         hv_d  = 1'b1;
      end

      if (out_free) begin
         if (rem_q != '0) begin
            do_d   = sr_q[Width-1:0];
            sr_d   = sr_q >> Width;
            rem_d  = rem_q - CW'(1);
            last_d = (rem_q == CW'(1));
            acth_d = 1'b1;
         end else if (hv_q) begin
            // SZ=0 encodes a full word; the wrap of 0-1 gives Ratio-1 remaining beats.
            do_d   = hr_q[Width-1:0];
            sr_d   = hr_q[WW-1:Width];
            rem_d  = hsz_q - CW'(1);
            last_d = (hsz_q == CW'(1));
            acth_d = 1'b1;
            hv_d   = 1'b0;
         end else begin
            acth_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         hr_q   <= '0;
         hsz_q  <= '0;
         hv_q   <= 1'b0;
         sr_q   <= '0;
         rem_q  <= '0;
         do_q   <= '0;
         last_q <= 1'b0;
         acth_q <= 1'b0;
      end else begin
         hr_q   <= hr_d;
         hsz_q  <= hsz_d;
         hv_q   <= hv_d;
         sr_q   <= sr_d;
         rem_q  <= rem_d;
         do_q   <= do_d;
         last_q <= last_d;
         acth_q <= acth_d;
      end
   end

   assign bus.NEXTL = ~hv_q;
   assign bus.ACTH  = acth_q;
   assign bus.DO    = do_q;
   assign bus.LAST  = last_q;
endmodule
